// File: rtl/img_eq_pkg.sv
// Shared constants and FSM state codes for the histogram-equalisation LUT builder.
package img_eq_pkg;

    localparam int NUM_LINES     = 64;
    localparam int FIELD_W       = 32;
    localparam int BINS_PER_LINE = 4;
    localparam int PIX_W         = 8;
    localparam int LINE_W        = FIELD_W * BINS_PER_LINE;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_MIN_RD    = 4'd1;
    localparam state_t ST_MIN_WAIT  = 4'd2;
    localparam state_t ST_MIN_SCAN  = 4'd3;
    localparam state_t ST_CDF_RD    = 4'd4;
    localparam state_t ST_CDF_WAIT  = 4'd5;
    localparam state_t ST_BIN_ACC   = 4'd6;
    localparam state_t ST_DIV_START = 4'd7;
    localparam state_t ST_DIV_WAIT  = 4'd8;
    localparam state_t ST_PACK      = 4'd9;
    localparam state_t ST_WT_LINE   = 4'd10;
    localparam state_t ST_WT_IDLE   = 4'd11;
    localparam state_t ST_COMPLETE  = 4'd12;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, DIV_W cycles per
// division, one-cycle done pulse; a start while busy is ignored.
module seq_divider #(
    parameter int DIV_W = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic             done
);

    localparam int CNT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] quo;
    logic [DIV_W-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic [DIV_W:0]   rem_sh;
    logic [DIV_W:0]   diff;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        rem_sh = {rem, quo[DIV_W-1]};
        diff   = rem_sh - {1'b0, dvs};
    end

    // Load on start, then shift/subtract until the counter runs out.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    rem  <= '0;
                    quo  <= dividend;
                    dvs  <= divisor;
                    cnt  <= CNT_W'(DIV_W);
                    busy <= 1'b1;
                end
            end else begin
                if (!diff[DIV_W]) begin
                    rem <= diff[DIV_W-1:0];
                    quo <= {quo[DIV_W-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[DIV_W-1:0];
                    quo <= {quo[DIV_W-2:0], 1'b0};
                end
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/cdf_div_ctrl.sv
// Histogram-equalisation LUT builder: pass 1 scans the histogram for total and
// cdf_min, pass 2 accumulates the cdf per bin, scales it through the divider,
// packs four 8-bit map entries per line and writes them to scratch memory.
//
// Memory handshakes (no valid/ready; timing is fixed):
//   read  - hist_mem_rd_addr is registered; hist_mem_rd_data is sampled exactly
//           RD_LAT cycles after the address appears; one read in flight.
//   write - sc_mem_wt_addr/data are valid only while sc_mem_wt_en is high,
//           which lasts one cycle and is followed by WT_GAP cycles with en low.
module cdf_div_ctrl
    import img_eq_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int WT_GAP = 2,
    parameter int DIV_W  = 40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          hist_done,
    input  logic [127:0]  hist_mem_rd_data,
    output logic [15:0]   hist_mem_rd_addr,
    output logic [15:0]   sc_mem_wt_addr,
    output logic [127:0]  sc_mem_wt_data,
    output logic          sc_mem_wt_en,
    output logic          div_sc_mem_wt_done,
    output logic [3:0]    dbg_state
);

    localparam logic [5:0] LAST_LINE = 6'(NUM_LINES - 1);

    state_t              state;
    state_t              next_state;
    logic [5:0]          line;
    logic [1:0]          bin;
    logic [7:0]          wait_cnt;
    logic [31:0]         total;
    logic [31:0]         cdf;
    logic [31:0]         cdf_min;
    logic                min_found;
    logic [LINE_W-1:0]   line_buf;
    logic [LINE_W-1:0]   out_buf;
    logic [DIV_W-1:0]    numer;

    logic                start_run;
    logic                rd_wait_last;
    logic                wt_wait_last;
    logic [31:0]         denom;
    logic                denom_zero;
    logic [LINE_W-1:0]   cur_line;
    logic [31:0]         cur_field;
    logic [31:0]         cdf_next;
    logic [31:0]         cdf_diff;
    logic [DIV_W-1:0]    numer_next;
    logic [31:0]         line_sum;
    logic                scan_hit;
    logic [31:0]         scan_val;
    logic [PIX_W-1:0]    map_val;

    logic                div_start;
    logic                div_done;
    logic [DIV_W-1:0]    div_quot;
    logic                unused_quot_hi;

    // Shared decode for the FSM and the datapath.
    always_comb begin
        start_run    = hist_done && enable;
        rd_wait_last = (wait_cnt == 8'(RD_LAT - 1));
        wt_wait_last = (wait_cnt == 8'(WT_GAP - 1));
        denom        = total - cdf_min;
        denom_zero   = (denom == 32'd0);
        // Bin 0 comes straight from the read port; later bins from the latched copy.
        cur_line     = (bin == 2'd0) ? hist_mem_rd_data : line_buf;
        cur_field    = cur_line[bin*FIELD_W +: FIELD_W];
        cdf_next     = cdf + cur_field;
        cdf_diff     = (cdf_next > cdf_min) ? (cdf_next - cdf_min) : 32'd0;
        numer_next   = DIV_W'(cdf_diff) * DIV_W'(255);
        map_val      = denom_zero ? '0 : div_quot[PIX_W-1:0];
    end

    // Pass-1 line summary: sum of all fields and the first nonzero field in bin order.
    always_comb begin
        line_sum = '0;
        scan_hit = 1'b0;
        scan_val = '0;
        for (int i = 0; i < BINS_PER_LINE; i++) begin
            line_sum = line_sum + hist_mem_rd_data[i*FIELD_W +: FIELD_W];
            if (!scan_hit && (hist_mem_rd_data[i*FIELD_W +: FIELD_W] != 32'd0)) begin
                scan_hit = 1'b1;
                scan_val = hist_mem_rd_data[i*FIELD_W +: FIELD_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (start_run) next_state = ST_MIN_RD;
            ST_MIN_RD:    next_state = ST_MIN_WAIT;
            ST_MIN_WAIT:  if (rd_wait_last) next_state = ST_MIN_SCAN;
            ST_MIN_SCAN:  next_state = (line == LAST_LINE) ? ST_CDF_RD : ST_MIN_RD;
            ST_CDF_RD:    next_state = ST_CDF_WAIT;
            ST_CDF_WAIT:  if (rd_wait_last) next_state = ST_BIN_ACC;
            ST_BIN_ACC:   next_state = denom_zero ? ST_PACK : ST_DIV_START;
            ST_DIV_START: next_state = ST_DIV_WAIT;
            ST_DIV_WAIT:  if (div_done) next_state = ST_PACK;
            ST_PACK:      next_state = (bin == 2'd3) ? ST_WT_LINE : ST_BIN_ACC;
            ST_WT_LINE:   next_state = ST_WT_IDLE;
            ST_WT_IDLE: begin
                if (wt_wait_last) begin
                    next_state = (line == LAST_LINE) ? ST_COMPLETE : ST_CDF_RD;
                end
            end
            ST_COMPLETE:  next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs: write strobe, done pulse, divider start.
    always_comb begin
        sc_mem_wt_en       = (state == ST_WT_LINE);
        div_sc_mem_wt_done = (state == ST_COMPLETE);
        div_start          = (state == ST_DIV_START);
        sc_mem_wt_addr     = sc_mem_wt_en ? {10'b0, line} : 16'd0;
        sc_mem_wt_data     = sc_mem_wt_en ? out_buf : '0;
    end

    // Datapath: counters, accumulators, read address and line packing.
    always_ff @(posedge clk) begin
        if (reset) begin
            line             <= '0;
            bin              <= '0;
            wait_cnt         <= '0;
            total            <= '0;
            cdf              <= '0;
            cdf_min          <= '0;
            min_found        <= 1'b0;
            line_buf         <= '0;
            out_buf          <= '0;
            numer            <= '0;
            hist_mem_rd_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_run) begin
                        line      <= '0;
                        bin       <= '0;
                        total     <= '0;
                        cdf       <= '0;
                        cdf_min   <= '0;
                        min_found <= 1'b0;
                    end
                end
                ST_MIN_RD, ST_CDF_RD: begin
                    hist_mem_rd_addr <= {10'b0, line};
                    wait_cnt         <= '0;
                    bin              <= '0;
                end
                ST_MIN_WAIT, ST_CDF_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                ST_MIN_SCAN: begin
                    total <= total + line_sum;
                    if (!min_found && scan_hit) begin
                        cdf_min   <= scan_val;
                        min_found <= 1'b1;
                    end
                    line <= (line == LAST_LINE) ? 6'd0 : line + 6'd1;
                end
                ST_BIN_ACC: begin
                    if (bin == 2'd0) begin
                        line_buf <= hist_mem_rd_data;
                    end
                    cdf   <= cdf_next;
                    numer <= numer_next;
                end
                ST_PACK: begin
                    out_buf[bin*FIELD_W +: FIELD_W] <= {{(FIELD_W-PIX_W){1'b0}}, map_val};
                    bin <= bin + 2'd1;
                end
                ST_WT_LINE: begin
                    wait_cnt <= '0;
                end
                ST_WT_IDLE: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (wt_wait_last && (line != LAST_LINE)) begin
                        line <= line + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    seq_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (numer),
        .divisor  (DIV_W'(denom)),
        .quotient (div_quot),
        .done     (div_done)
    );

    assign unused_quot_hi = ^div_quot[DIV_W-1:PIX_W];
    assign dbg_state      = state;

endmodule
